// File: rtl/return_addr_stack.sv
// return_addr_stack: jal/jalr push pc+4, jr pops a predicted target for fetch.
// Optional RAS_STATS_EN adds saturating push/pop/miss counters.
module return_addr_stack #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int AW    = 32
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic [AW-1:0]    pc,
  output logic [AW-1:0]    pred_target,
  output logic             pred_valid,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
`ifdef RAS_STATS_EN
  ,
  output logic [15:0]      push_cnt,
  output logic [15:0]      pop_cnt,
  output logic [15:0]      miss_cnt
`endif
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  logic [AW-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] tp_q, tp_d;
  logic [PTR_W:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic is_jal, is_jalr, is_jr, upd, push, pop;
  assign is_jal  = opcode == 6'b000011;
  assign is_jalr = opcode == 6'b000000 && func == 6'b001001;
  assign is_jr   = opcode == 6'b000000 && func == 6'b001000;
  assign upd     = valid & ~stall & ~flush;
  assign push    = upd & (is_jal | is_jalr);
  assign pop     = upd & is_jr;
  assign empty   = cnt_q == '0;
  assign full    = cnt_q == FULL_CNT;
  assign count   = cnt_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;
  assign pred_target = empty ? '0 : mem_q[tp_q];
  assign pred_valid  = valid & is_jr & ~empty;
  // Flush is not gated by stall: a mispredict must always clear the stack.
  always_comb begin
    tp_d  = tp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (flush) begin
      tp_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (push) begin
      tp_d  = tp_q + 1'b1;
      cnt_d = full ? cnt_q : cnt_q + 1'b1;
      ovf_d = ovf_q | full;
    end else if (pop) begin
      tp_d  = empty ? tp_q : tp_q - 1'b1;
      cnt_d = empty ? cnt_q : cnt_q - 1'b1;
      unf_d = unf_q | empty;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  // Entry storage is deliberately unreset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[tp_d] <= pc + AW'(4);
  end
`ifdef RAS_STATS_EN
  logic [15:0] push_q, pop_q, miss_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_q <= '0;
      pop_q  <= '0;
      miss_q <= '0;
    end else begin
      if (push && push_q != 16'hFFFF) push_q <= push_q + 1'b1;
      if (pop && !empty && pop_q != 16'hFFFF) pop_q <= pop_q + 1'b1;
      if (pop && empty && miss_q != 16'hFFFF) miss_q <= miss_q + 1'b1;
    end
  end
  assign push_cnt = push_q;
  assign pop_cnt  = pop_q;
  assign miss_cnt = miss_q;
`endif
endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack: randomized + directed stimulus against a queue-based stack model;
// expectations go to a scoreboard that a separate monitor drains every cycle.
module tb_return_addr_stack;
  localparam int DEPTH = 8;
  typedef struct {
    logic [31:0] tgt;
    logic        pv, emp, fl, ov, un;
    logic [3:0]  cnt;
    logic [15:0] npush, npop, nmiss;
  } exp_t;
  logic clk = 0, rst_s = 1, v_s = 0, st_s = 0, fl_s = 0;
  logic [5:0] op_s = 0, fn_s = 0;
  logic [31:0] pc_s = 0;
  logic [31:0] tgt_o;
  logic pv_o, emp_o, full_o, ovf_o, unf_o;
  logic [3:0] cnt_o;
  logic [15:0] push_o, pop_o, miss_o;
  exp_t sb[$];
  logic [31:0] stk[$];
  bit movf = 0, munf = 0;
  logic [15:0] mpush = 0, mpop = 0, mmiss = 0;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  return_addr_stack #(.DEPTH(DEPTH), .PTR_W(3), .AW(32)) dut (
    .clk(clk), .reset(rst_s), .valid(v_s), .stall(st_s), .flush(fl_s),
    .opcode(op_s), .func(fn_s), .pc(pc_s),
    .pred_target(tgt_o), .pred_valid(pv_o), .count(cnt_o),
    .empty(emp_o), .full(full_o), .ovf(ovf_o), .unf(unf_o)
`ifdef RAS_STATS_EN
    , .push_cnt(push_o), .pop_cnt(pop_o), .miss_cnt(miss_o)
`endif
  );
`ifndef RAS_STATS_EN
  assign push_o = '0;
  assign pop_o  = '0;
  assign miss_o = '0;
`endif
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  function automatic logic [15:0] sat(input logic [15:0] x);
    return x == 16'hFFFF ? x : x + 16'd1;
  endfunction
  // Drive one cycle, record what the outputs must show during it, then advance the model.
  task automatic cyc(input bit v, input bit st, input bit fl, input bit rs,
                     input logic [5:0] op, input logic [5:0] fn, input logic [31:0] pcv);
    exp_t e;
    bit jal, jalr, jr, up;
    @(posedge clk);
    #1;
    rst_s = rs; v_s = v; st_s = st; fl_s = fl; op_s = op; fn_s = fn; pc_s = pcv;
    if (rs) begin
      stk.delete();
      movf = 0; munf = 0; mpush = 0; mpop = 0; mmiss = 0;
    end
    jal  = op == 6'd3;
    jalr = op == 6'd0 && fn == 6'd9;
    jr   = op == 6'd0 && fn == 6'd8;
    e.tgt = stk.size() != 0 ? stk[$] : 32'd0;
    e.pv  = v && jr && stk.size() != 0;
    e.cnt = 4'(stk.size());
    e.emp = stk.size() == 0;
    e.fl  = stk.size() == DEPTH;
    e.ov  = movf;
    e.un  = munf;
    e.npush = mpush; e.npop = mpop; e.nmiss = mmiss;
    sb.push_back(e);
    if (!rs) begin
      up = v && !st && !fl;
      if (fl) begin
        stk.delete();
        movf = 0; munf = 0;
      end else if (up && (jal || jalr)) begin
        if (stk.size() == DEPTH) begin
          void'(stk.pop_front());
          movf = 1;
        end
        stk.push_back(pcv + 32'd4);
        mpush = sat(mpush);
      end else if (up && jr) begin
        if (stk.size() != 0) begin
          void'(stk.pop_back());
          mpop = sat(mpop);
        end else begin
          munf = 1;
          mmiss = sat(mmiss);
        end
      end
    end
  endtask
  task automatic jal_(input logic [31:0] p);  cyc(1, 0, 0, 0, 6'd3, 6'd0, p); endtask
  task automatic jr_();                       cyc(1, 0, 0, 0, 6'd0, 6'd8, 32'h0); endtask
  task automatic idle();                      cyc(0, 0, 0, 0, 6'd0, 6'd0, 32'h0); endtask
  task automatic rst_();                      cyc(0, 0, 0, 1, 6'd0, 6'd0, 32'h0); endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pred_target", tgt_o, e.tgt);
        chk("pred_valid", 32'(pv_o), 32'(e.pv));
        chk("count", 32'(cnt_o), 32'(e.cnt));
        chk("empty", 32'(emp_o), 32'(e.emp));
        chk("full", 32'(full_o), 32'(e.fl));
        chk("ovf", 32'(ovf_o), 32'(e.ov));
        chk("unf", 32'(unf_o), 32'(e.un));
`ifdef RAS_STATS_EN
        chk("push_cnt", 32'(push_o), 32'(e.npush));
        chk("pop_cnt", 32'(pop_o), 32'(e.npop));
        chk("miss_cnt", 32'(miss_o), 32'(e.nmiss));
`endif
      end
    end
  end
  initial begin
    logic [5:0] op, fn;
    logic [31:0] p;
    bit rs, fl, st, v;
    rst_(); rst_(); idle();
    jal_(32'h100); jal_(32'h200); jal_(32'h300);
    jr_(); jr_(); jr_(); idle();
    for (int k = 1; k <= 9; k++) jal_(32'h10 * k);
    for (int k = 0; k < 9; k++) jr_();
    idle();
    cyc(1, 0, 1, 0, 6'd0, 6'd0, 32'h0);
    jr_(); idle();
    cyc(1, 0, 1, 0, 6'd0, 6'd0, 32'h0); idle();
    cyc(1, 1, 0, 0, 6'd3, 6'd0, 32'h400); idle();
    jal_(32'h400); idle();
    cyc(1, 0, 0, 0, 6'd0, 6'd9, 32'h500); jr_(); jr_(); jr_();
    jal_(32'h1000); jal_(32'h2000); jal_(32'h3000);
    cyc(1, 0, 0, 1, 6'd3, 6'd0, 32'h4000);
    idle(); jal_(32'hFFFF_FFFC); jr_();
    rst_();
    for (int k = 0; k < 5; k++) jal_(32'h800 + 32'h4 * k);
    for (int k = 0; k < 6; k++) jr_();
    cyc(0, 0, 1, 0, 6'd0, 6'd0, 32'h0); idle();
    for (int i = 0; i < 2000; i++) begin
      rs = $urandom_range(0, 199) == 0;
      fl = !rs && $urandom_range(0, 19) == 0;
      st = !fl && $urandom_range(0, 4) == 0;
      v  = $urandom_range(0, 6) != 0;
      fn = 6'($urandom);
      op = 6'd0;
      case ($urandom_range(0, 5))
        0, 1: op = 6'd3;
        2: fn = 6'd8;
        3: fn = 6'd9;
        4: ;
        default: op = 6'($urandom);
      endcase
      p = $urandom_range(0, 9) == 0 ? 32'hFFFF_FFFC - 32'($urandom_range(0, 3) * 4) : $urandom;
      cyc(v, st, fl, rs, op, fn, p);
    end
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
